// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer: applies {a,b}=00..11 to a gate, samples y after a settle time, scores it against a truth table.
module gate_truth_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter logic [3:0] TRUTH_TABLE = 4'b1000,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask,
  output logic [2:0] err_cnt,
  output logic       aborted
);
  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);
  state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0] mask_n;
  logic [2:0] ecnt_n;
  logic pass_n, aborted_n, sample, miss;
  assign sample = state == APPLY && cnt == LAST;
  // 4-state compare so an x or z on y is scored as a mismatch
  assign miss = !(y === TRUTH_TABLE[idx]);
  assign busy = state == APPLY;
  assign done = state == DONE;
  assign a = busy & idx[1];
  assign b = busy & idx[0];
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    mask_n = err_mask;
    ecnt_n = err_cnt;
    pass_n = pass;
    aborted_n = aborted;
    if (state == APPLY) begin
      if (abort) begin
        state_n = IDLE;
        aborted_n = 1'b1;
        pass_n = 1'b0;
      end else begin
        cnt_n = sample ? '0 : cnt + CNT_W'(1);
        if (sample && miss) begin
          mask_n[idx] = 1'b1;
          ecnt_n = err_cnt + 3'd1;
        end
        if (sample) begin
          idx_n = idx + 2'd1;
          state_n = idx == 2'd3 ? DONE : APPLY;
          pass_n = idx == 2'd3 ? ecnt_n == 3'd0 : pass;
        end
      end
    end else begin
      state_n = start ? APPLY : IDLE;
      if (start) begin
        idx_n = '0;
        cnt_n = '0;
        mask_n = '0;
        ecnt_n = '0;
        pass_n = 1'b0;
        aborted_n = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      err_mask <= '0;
      err_cnt <= '0;
      pass <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      err_mask <= mask_n;
      err_cnt <= ecnt_n;
      pass <= pass_n;
      aborted <= aborted_n;
    end
  end
endmodule

// File: tb/tb_gate_truth_sequencer.sv
// tb_gate_truth_sequencer: two instances (settle 4 and 1) checked every cycle against an elapsed-time reference model.
module tb_gate_truth_sequencer;
  localparam logic [3:0] TT = 4'b1000;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic y0, a0, b0, busy0, done0, pass0, aborted0;
  logic y1, a1, b1, busy1, done1, pass1, aborted1;
  logic [3:0] mask0, mask1;
  logic [2:0] cnt0, cnt1;
  int mode = 0, checks = 0, errors = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  function automatic logic gate(int m, logic [1:0] v);
    case (m)
      0: return v[1] & v[0];
      1: return v[1] | v[0];
      2: return v[1] ^ v[0];
      3: return 1'b0;
      4: return 1'b1;
      default: return ~(v[1] & v[0]);
    endcase
  endfunction
  function automatic int settle(int i);
    return i == 0 ? 4 : 1;
  endfunction
  assign y0 = gate(mode, {a0, b0});
  assign y1 = gate(mode, {a1, b1});
  gate_truth_sequencer #(.SETTLE_CYCLES(4), .TRUTH_TABLE(TT), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y(y0), .a(a0), .b(b0), .busy(busy0),
    .done(done0), .pass(pass0), .err_mask(mask0), .err_cnt(cnt0), .aborted(aborted0));
  gate_truth_sequencer #(.SETTLE_CYCLES(1), .TRUTH_TABLE(TT), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y(y1), .a(a1), .b(b1), .busy(busy1),
    .done(done1), .pass(pass1), .err_mask(mask1), .err_cnt(cnt1), .aborted(aborted1));
  bit m_run[2], m_pass[2], m_abt[2], m_done[2];
  int m_t[2], m_cnt[2];
  logic [3:0] m_mask[2];
  // Reference: a run is just "cycles elapsed since start"; vector = t/S, sample when t%S == S-1
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_run[i] = 0; m_pass[i] = 0; m_abt[i] = 0; m_done[i] = 0; m_t[i] = 0; m_cnt[i] = 0; m_mask[i] = 0;
      end else if (m_run[i]) begin
        if (abort) begin
          m_run[i] = 0; m_abt[i] = 1; m_pass[i] = 0;
        end else begin
          int v;
          v = m_t[i] / settle(i);
          if (m_t[i] % settle(i) == settle(i) - 1) begin
            if (gate(mode, 2'(v)) != TT[v]) begin m_mask[i][v] = 1; m_cnt[i]++; end
            if (v == 3) begin m_run[i] = 0; m_done[i] = 1; m_pass[i] = m_cnt[i] == 0; end
          end
          m_t[i]++;
        end
      end else begin
        m_done[i] = 0;
        if (start) begin
          m_run[i] = 1; m_t[i] = 0; m_mask[i] = 0; m_cnt[i] = 0; m_pass[i] = 0; m_abt[i] = 0;
        end
      end
    end
  end
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int ab;
        ab = m_run[i] ? m_t[i] / settle(i) : 0;
        chk($sformatf("dut%0d ab", i), i ? {a1, b1} : {a0, b0}, ab);
        chk($sformatf("dut%0d busy", i), i ? busy1 : busy0, m_run[i]);
        chk($sformatf("dut%0d done", i), i ? done1 : done0, m_done[i]);
        chk($sformatf("dut%0d pass", i), i ? pass1 : pass0, m_pass[i]);
        chk($sformatf("dut%0d err_mask", i), i ? mask1 : mask0, m_mask[i]);
        chk($sformatf("dut%0d err_cnt", i), i ? cnt1 : cnt0, m_cnt[i]);
        chk($sformatf("dut%0d aborted", i), i ? aborted1 : aborted0, m_abt[i]);
      end
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1;
    tick(1);
    start = 0;
  endtask
  initial begin
    tick(3);
    rst = 0;
    chk_en = 1;
    chk("reset busy", busy0, 0);
    chk("reset err_mask", mask0, 0);
    // AND gate against AND table: clean run, done 4*S+1 edges after start
    mode = 0;
    tick(5);
    pulse_start();
    tick(15);
    chk("and done early", done0, 0);
    tick(1);
    chk("and done", done0, 1);
    chk("and pass", pass0, 1);
    chk("and err_cnt", cnt0, 0);
    // OR gate against AND table
    mode = 1;
    tick(2);
    pulse_start();
    tick(16);
    chk("or done", done0, 1);
    chk("or err_mask", mask0, 4'b0110);
    chk("or err_cnt", cnt0, 2);
    chk("or pass", pass0, 0);
    chk("or settle1 err_mask", mask1, 4'b0110);
    // Stuck-at-0, abort during vector 10
    mode = 3;
    tick(2);
    pulse_start();
    tick(8);
    chk("abort ab before", {a0, b0}, 2'b10);
    abort = 1;
    tick(1);
    abort = 0;
    chk("abort busy", busy0, 0);
    chk("abort aborted", aborted0, 1);
    chk("abort err_mask", mask0, 0);
    chk("abort s1 not aborted", aborted1, 0);
    tick(20);
    chk("abort no done", done0, 0);
    // start while busy is ignored, then start in the DONE cycle restarts
    mode = 2;
    pulse_start();
    tick(5);
    pulse_start();
    tick(10);
    chk("restart done", done0, 1);
    chk("xor err_mask", mask0, 4'b1110);
    start = 1;
    tick(1);
    start = 0;
    chk("done-cycle start busy", busy0, 1);
    chk("done-cycle start cleared", cnt0, 0);
    // rst during the third vector
    tick(8);
    rst = 1;
    tick(1);
    rst = 0;
    chk("rst busy", busy0, 0);
    chk("rst err_mask", mask0, 0);
    mode = 0;
    pulse_start();
    tick(16);
    chk("post-rst done", done0, 1);
    chk("post-rst pass", pass0, 1);
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom % 8) == 0;
      abort = ($urandom % 24) == 0;
      rst = ($urandom % 300) == 0;
      if ($urandom % 16 == 0) mode = $urandom % 6;
      tick(1);
    end
    start = 0; abort = 0; rst = 0;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
